mem_port_arbiter: RTL and testbench

- Shares the single RAMHelper port between the instruction-fetch requester (IF) and the load/store requester (LS) of rvcpu.
- Replaces the static "data read steals the port" mux in SimTop.
- Adds valid/ready handshakes, a 1-cycle pipelined response, starvation-bounded LS priority, a fetch flush, and address-range checking.
- Converts byte addresses into RAMHelper 64-bit word indices.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_addr_check.sv | 18 +
 rtl/mem_port_arbiter.sv | 89 ++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: response-source encodings, address defaults and the byte-to-word index helper
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_IF = 2'd1, SRC_LS = 2'd2} resp_src_t;
  typedef struct packed {
    resp_src_t src;
    logic      hi;
    logic      err;
    logic      is_store;
  } resp_t;
  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;
  localparam logic [63:0] DEFAULT_RAM_WORDS = 64'h0800_0000;
  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr, input logic [63:0] base);
    return (addr - base) >> 3;
  endfunction
endpackage

// File: rtl/mem_addr_check.sv
// mem_addr_check: range/alignment check and RAM word index for one requester
module mem_addr_check
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter logic [63:0] RAM_WORDS   = DEFAULT_RAM_WORDS,
  parameter bit          CHECK_ALIGN = 1'b0
) (
  input  logic [63:0] addr,
  output logic        err,
  output logic [63:0] idx
);
  logic in_range;
  assign in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + (RAM_WORDS << 3));
  // Fetches must be 4-byte aligned; loads/stores rely on the mask instead
  assign err = !in_range || (CHECK_ALIGN && addr[1:0] != 2'b00);
  assign idx = addr_to_idx(addr, BASE_ADDR);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAMHelper port between fetch and load/store with
// starvation-bounded LS priority and a fixed 1-cycle response
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter logic [63:0] RAM_WORDS     = DEFAULT_RAM_WORDS,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [63:0] if_req_addr,
  output logic        if_req_ready,
  input  logic        if_flush,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_inst,
  output logic        if_resp_err,
  input  logic        ls_req_valid,
  input  logic        ls_req_wen,
  input  logic [63:0] ls_req_addr,
  input  logic [63:0] ls_req_wdata,
  input  logic [63:0] ls_req_wmask,
  output logic        ls_req_ready,
  output logic        ls_resp_valid,
  output logic [63:0] ls_resp_rdata,
  output logic        ls_resp_err,
  output logic        ram_ren,
  output logic [63:0] ram_ridx,
  input  logic [63:0] ram_rdata,
  output logic        ram_wen,
  output logic [63:0] ram_widx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask
);
  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);
  logic [SW-1:0] streak;
  resp_t resp;
  logic if_err, ls_err, if_elig, if_grant, ls_grant, ren, wen;
  logic [63:0] if_idx, ls_idx;

  mem_addr_check #(.BASE_ADDR(BASE_ADDR), .RAM_WORDS(RAM_WORDS), .CHECK_ALIGN(1'b1)) u_if_chk (
    .addr(if_req_addr),
    .err (if_err),
    .idx (if_idx)
  );

  mem_addr_check #(.BASE_ADDR(BASE_ADDR), .RAM_WORDS(RAM_WORDS), .CHECK_ALIGN(1'b0)) u_ls_chk (
    .addr(ls_req_addr),
    .err (ls_err),
    .idx (ls_idx)
  );

  assign if_elig  = if_req_valid && !if_flush;
  assign if_grant = if_elig && (!ls_req_valid || streak == STREAK_MAX);
  assign ls_grant = ls_req_valid && !if_grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak <= '0;
      resp   <= resp_t'{SRC_NONE, 1'b0, 1'b0, 1'b0};
    end else begin
      streak <= (if_grant || !if_elig) ? '0 : (ls_grant && streak != STREAK_MAX) ? streak + 1'b1 : streak;
      resp   <= if_grant ? resp_t'{SRC_IF, if_req_addr[2], if_err, 1'b0} :
                ls_grant ? resp_t'{SRC_LS, ls_req_addr[2], ls_err, ls_req_wen} :
                           resp_t'{SRC_NONE, 1'b0, 1'b0, 1'b0};
    end
  end

  // Everything visible is gated by reset so the port goes quiet immediately
  assign if_req_ready = !reset && if_grant;
  assign ls_req_ready = !reset && ls_grant;
  assign ren = !reset && ((if_grant && !if_err) || (ls_grant && !ls_req_wen && !ls_err));
  assign wen = !reset && ls_grant && ls_req_wen && !ls_err;
  assign ram_ren   = ren;
  assign ram_ridx  = ren ? (if_grant ? if_idx : ls_idx) : '0;
  assign ram_wen   = wen;
  assign ram_widx  = wen ? ls_idx : '0;
  assign ram_wdata = wen ? ls_req_wdata : '0;
  assign ram_wmask = wen ? ls_req_wmask : '0;

  assign if_resp_valid = !reset && resp.src == SRC_IF && !if_flush;
  assign if_resp_err   = if_resp_valid && resp.err;
  assign if_resp_inst  = (if_resp_valid && !resp.err) ? (resp.hi ? ram_rdata[63:32] : ram_rdata[31:0]) : '0;
  assign ls_resp_valid = !reset && resp.src == SRC_LS;
  assign ls_resp_err   = ls_resp_valid && resp.err;
  assign ls_resp_rdata = (ls_resp_valid && !resp.err && !resp.is_store) ? ram_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus random checks against a queue-based reference model
module tb_mem_port_arbiter;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] WORDS = 64'h0800_0000;
  localparam logic [63:0] LIMIT = BASE + WORDS * 64'd8;
  localparam int MAX = 4;

  logic clock = 1'b0, reset = 1'b1;
  logic if_req_valid, if_flush, ls_req_valid, ls_req_wen;
  logic [63:0] if_req_addr, ls_req_addr, ls_req_wdata, ls_req_wmask, ram_rdata;
  logic if_req_ready, if_resp_valid, if_resp_err, ls_req_ready, ls_resp_valid, ls_resp_err, ram_ren, ram_wen;
  logic [31:0] if_resp_inst;
  logic [63:0] ls_resp_rdata, ram_ridx, ram_widx, ram_wdata, ram_wmask;

  typedef struct {
    int          kind;
    logic [63:0] addr;
    bit          err;
    bit          store;
  } rsp_t;
  rsp_t q[$];
  int checks = 0, failures = 0, streak = 0;
  bit last_if_ready;
  logic [9:0] order;

  mem_port_arbiter #(.BASE_ADDR(BASE), .RAM_WORDS(WORDS), .MAX_LS_STREAK(MAX)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready), .if_flush(if_flush),
    .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_wen(ls_req_wen), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata), .ls_resp_err(ls_resp_err),
    .ram_ren(ram_ren), .ram_ridx(ram_ridx), .ram_rdata(ram_rdata),
    .ram_wen(ram_wen), .ram_widx(ram_widx), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return a >= BASE && a < LIMIT;
  endfunction

  function automatic logic [63:0] word(input logic [63:0] a);
    return (a - BASE) / 64'd8;
  endfunction

  function automatic logic [63:0] rnd_addr();
    case ($urandom_range(0, 9))
      0: return 64'($urandom_range(0, 32'h7FFF_FFFF));
      1: return LIMIT + 64'($urandom_range(0, 255));
      2: return LIMIT - 64'd8 * 64'($urandom_range(1, 4)) + 64'($urandom_range(0, 7));
      3: return BASE + 64'($urandom_range(0, 4095)) * 64'd4 + 64'($urandom_range(1, 3));
      default: return BASE + 64'($urandom_range(0, 4095)) * 64'd4;
    endcase
  endfunction

  task automatic idle();
    if_req_valid = 0; if_flush = 0; ls_req_valid = 0; ls_req_wen = 0;
    if_req_addr = 0; ls_req_addr = 0; ls_req_wdata = 0; ls_req_wmask = 0;
  endtask

  task automatic set_if(input logic [63:0] a);
    if_req_valid = 1; if_req_addr = a;
  endtask

  task automatic set_ls(input bit w, input logic [63:0] a, input logic [63:0] d, input logic [63:0] m);
    ls_req_valid = 1; ls_req_wen = w; ls_req_addr = a; ls_req_wdata = d; ls_req_wmask = m;
  endtask

  task automatic push(input int k, input logic [63:0] a, input bit e, input bit s);
    rsp_t r;
    r.kind = k; r.addr = a; r.err = e; r.store = s;
    q.push_back(r);
  endtask

  task automatic chk_all_zero();
    chk("rst_if_ready", if_req_ready, 0);
    chk("rst_ls_ready", ls_req_ready, 0);
    chk("rst_ram_ren", ram_ren, 0);
    chk("rst_ram_wen", ram_wen, 0);
    chk("rst_ram_ridx", ram_ridx, 0);
    chk("rst_ram_widx", ram_widx, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ram_wmask", ram_wmask, 0);
    chk("rst_if_resp_valid", if_resp_valid, 0);
    chk("rst_if_resp_inst", if_resp_inst, 0);
    chk("rst_if_resp_err", if_resp_err, 0);
    chk("rst_ls_resp_valid", ls_resp_valid, 0);
    chk("rst_ls_resp_rdata", ls_resp_rdata, 0);
    chk("rst_ls_resp_err", ls_resp_err, 0);
  endtask

  task automatic tick();
    bit if_el, g_if, g_ls, if_ok, ls_ok, e_ren, e_wen, e_ifv, e_lsv;
    rsp_t r;
    #1;
    if_el = if_req_valid && !if_flush;
    g_if  = if_el && (!ls_req_valid || streak == MAX);
    g_ls  = ls_req_valid && !g_if;
    if_ok = in_rng(if_req_addr) && (if_req_addr % 64'd4 == 0);
    ls_ok = in_rng(ls_req_addr);
    e_ren = (g_if && if_ok) || (g_ls && !ls_req_wen && ls_ok);
    e_wen = g_ls && ls_req_wen && ls_ok;
    chk("if_req_ready", if_req_ready, g_if);
    chk("ls_req_ready", ls_req_ready, g_ls);
    chk("ram_ren", ram_ren, e_ren);
    chk("ram_ridx", ram_ridx, !e_ren ? 64'd0 : word(g_if ? if_req_addr : ls_req_addr));
    chk("ram_wen", ram_wen, e_wen);
    chk("ram_widx", ram_widx, e_wen ? word(ls_req_addr) : 64'd0);
    chk("ram_wdata", ram_wdata, e_wen ? ls_req_wdata : 64'd0);
    chk("ram_wmask", ram_wmask, e_wen ? ls_req_wmask : 64'd0);
    r.kind = 0; r.addr = 0; r.err = 0; r.store = 0;
    if (q.size() > 0) r = q.pop_front();
    e_ifv = r.kind == 1 && !if_flush;
    e_lsv = r.kind == 2;
    chk("if_resp_valid", if_resp_valid, e_ifv);
    chk("if_resp_inst", if_resp_inst,
        (e_ifv && !r.err) ? (r.addr % 64'd8 >= 4 ? ram_rdata >> 32 : ram_rdata & 64'hFFFF_FFFF) : 64'd0);
    chk("if_resp_err", if_resp_err, e_ifv && r.err);
    chk("ls_resp_valid", ls_resp_valid, e_lsv);
    chk("ls_resp_rdata", ls_resp_rdata, (e_lsv && !r.err && !r.store) ? ram_rdata : 64'd0);
    chk("ls_resp_err", ls_resp_err, e_lsv && r.err);
    last_if_ready = if_req_ready;
    if (g_if) push(1, if_req_addr, !if_ok, 0);
    else if (g_ls) push(2, ls_req_addr, !ls_ok, ls_req_wen);
    streak = (g_if || !if_el) ? 0 : streak + 1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    ram_rdata = 64'h0;
    set_if(BASE);
    set_ls(1, BASE + 64'h8, 64'h55, 64'hFF);
    #1;
    chk_all_zero();
    @(posedge clock);
    #1;
    reset = 0;
    idle();
    // single fetch, upper half of the word
    set_if(64'h8000_0004); tick();
    idle(); ram_rdata = 64'h1111_2222_3333_4444; tick();
    // single load
    set_ls(0, 64'h8000_0018, 0, 0); ram_rdata = 0; tick();
    idle(); ram_rdata = 64'hDEAD_BEEF_0000_0001; tick();
    // store then ack
    set_ls(1, 64'h8000_0010, 64'hAB, 64'hFFFF_FFFF); tick();
    idle(); ram_rdata = 64'h1234; tick();
    // contention: fixed grant order
    order = '0;
    set_if(BASE + 64'h100);
    set_ls(0, BASE + 64'h40, 0, 0);
    for (int i = 0; i < 10; i++) begin
      ram_rdata = {$urandom(), $urandom()};
      tick();
      order = {order[8:0], last_if_ready};
    end
    chk("grant_order", order, 10'b00001_00001);
    idle(); tick();
    // out-of-range load and misaligned fetch
    set_ls(0, 64'h1000_0000, 0, 0); tick();
    idle(); set_if(64'h8000_0002); ram_rdata = 64'hFFFF_FFFF_FFFF_FFFF; tick();
    idle(); tick();
    // range edges
    set_ls(0, LIMIT - 64'd8, 0, 0); tick();
    set_ls(0, LIMIT, 0, 0); ram_rdata = 64'h77; tick();
    set_ls(1, LIMIT, 64'h9, 64'hF); tick();
    idle(); set_if(BASE - 64'd4); tick();
    idle(); tick();
    // flush in response cycle, then flush blocking an IF grant
    set_if(BASE + 64'h20); tick();
    idle(); if_flush = 1; ram_rdata = 64'hCAFE; tick();
    set_if(BASE + 64'h24); if_flush = 1; set_ls(0, BASE + 64'h28, 0, 0); tick();
    idle(); if_flush = 1; ram_rdata = 64'hBEEF_0000_AAAA_5555; tick();
    // back-to-back fetches
    set_if(BASE); tick();
    set_if(BASE + 64'h4); ram_rdata = 64'h0102_0304_0506_0708; tick();
    idle(); ram_rdata = 64'h1112_1314_1516_1718; tick();
    // reset between a grant and its response
    set_if(BASE + 64'h8); tick();
    set_ls(1, BASE + 64'h8, 64'h1, 64'h1);
    reset = 1;
    #1;
    chk_all_zero();
    @(posedge clock);
    #1;
    reset = 0; q.delete(); streak = 0;
    idle(); ram_rdata = 64'hAAAA_BBBB_CCCC_DDDD; tick();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      if_req_valid = 1'($urandom_range(0, 1));
      if_flush = $urandom_range(0, 7) == 0;
      if_req_addr = rnd_addr();
      ls_req_valid = 1'($urandom_range(0, 1));
      ls_req_wen = 1'($urandom_range(0, 1));
      ls_req_addr = rnd_addr();
      ls_req_wdata = {$urandom(), $urandom()};
      ls_req_wmask = {$urandom(), $urandom()};
      ram_rdata = {$urandom(), $urandom()};
      tick();
    end
    idle(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
